// File: rtl/axis_burst_drain.sv
// Burst drain: waits for a full burst in the TX FIFO, streams it out with tlast, then idles a gap.
// Optional AXIS_BURST_DRAIN_STATS_EN adds burst_count and underrun_count outputs.
module axis_burst_drain #(
  parameter int DATA_W     = 32,
  parameter int BURST_LEN  = 16,
  parameter int CNT_W      = 32,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [CNT_W-1:0]  axis_rd_data_count,
  input  logic              prog_empty,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              underrun
`ifdef AXIS_BURST_DRAIN_STATS_EN
  ,
  output logic [31:0]       burst_count,
  output logic [15:0]       underrun_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FLUSH,
    GAP
  } state_t;

  // Widen the compare so a BURST_LEN beyond the count range never matches.
  localparam int CMP_W = (CNT_W > 17) ? CNT_W : 17;
  localparam logic [CMP_W-1:0] LEN_CMP = CMP_W'($unsigned(BURST_LEN));
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);
  localparam logic [31:0] LAST_GAP = 32'(GAP_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [15:0] beat_cnt;
  logic [31:0] gap_cnt;
  logic        start;
  logic        rdy;
  logic        accept;
  logic        last_acc;
  logic        out_hs;

  assign start    = (CMP_W'(axis_rd_data_count) >= LEN_CMP) && !prog_empty;
  assign rdy      = resetn && (state == BURST)
                    && (!m_axis_tvalid || m_axis_tready);
  assign accept   = rdy && s_axis_tvalid;
  assign last_acc = accept && (beat_cnt == LAST_BEAT);
  assign out_hs   = m_axis_tvalid && m_axis_tready;

  assign s_axis_tready = rdy;
  assign underrun      = rdy && !s_axis_tvalid;
  assign busy          = resetn && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = BURST;
      BURST: if (last_acc) state_nx = FLUSH;
      FLUSH: begin
        if (out_hs && m_axis_tlast)
          state_nx = (GAP_CYCLES == 0) ? IDLE : GAP;
      end
      GAP:   if (gap_cnt == LAST_GAP) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      beat_cnt      <= '0;
      gap_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
    end else begin
      if (state == IDLE)  beat_cnt <= '0;
      else if (accept)    beat_cnt <= beat_cnt + 16'd1;
      gap_cnt <= (state == GAP) ? gap_cnt + 32'd1 : 32'd0;
      // A handshake and a new accept on one edge simply reload.
      if (accept) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
        m_axis_tlast  <= last_acc;
      end else if (out_hs) begin
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
      end
    end
  end

`ifdef AXIS_BURST_DRAIN_STATS_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      burst_count    <= '0;
      underrun_count <= '0;
    end else begin
      if (state == FLUSH && state_nx != FLUSH)
        burst_count <= burst_count + 32'd1;
      if (underrun && underrun_count != 16'hFFFF)
        underrun_count <= underrun_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_burst_drain.sv
// Directed bench for axis_burst_drain: cycle vector table plus burst sequences.
// Two instances: GAP_CYCLES=4 (dut) and GAP_CYCLES=0 (dut0).
module tb_axis_burst_drain;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] count;
  logic        pe;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        und;

  logic [31:0] count0;
  logic [31:0] s_tdata0;
  logic        s_tvalid0;
  logic        s_tready0;
  logic [31:0] m_tdata0;
  logic        m_tvalid0;
  logic        m_tlast0;
  logic        busy0;
  logic        und0;

`ifdef AXIS_BURST_DRAIN_STATS_EN
  logic [31:0] bc;
  logic [15:0] uc;
  logic [31:0] bc0;
  logic [15:0] uc0;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axis_burst_drain #(
    .DATA_W(32), .BURST_LEN(16), .CNT_W(32), .GAP_CYCLES(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .axis_rd_data_count(count), .prog_empty(pe),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
    .busy(busy), .underrun(und)
`ifdef AXIS_BURST_DRAIN_STATS_EN
    , .burst_count(bc), .underrun_count(uc)
`endif
  );

  axis_burst_drain #(
    .DATA_W(32), .BURST_LEN(16), .CNT_W(32), .GAP_CYCLES(0)
  ) dut0 (
    .clk(clk), .resetn(resetn),
    .axis_rd_data_count(count0), .prog_empty(1'b0),
    .s_axis_tdata(s_tdata0), .s_axis_tvalid(s_tvalid0),
    .s_axis_tready(s_tready0),
    .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tready(1'b1), .m_axis_tlast(m_tlast0),
    .busy(busy0), .underrun(und0)
`ifdef AXIS_BURST_DRAIN_STATS_EN
    , .burst_count(bc0), .underrun_count(uc0)
`endif
  );

  typedef struct {
    logic        rn;
    logic [31:0] cnt;
    logic        pe;
    logic        sv;
    logic [31:0] sd;
    logic        mr;
    logic        busy;
    logic        str;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic        und;
    bit          cd;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_burst(input logic [31:0] base, input int period,
                           input int stall_at, input int stall_len,
                           input int abort_at, input int exp_gap);
    int acc, outn, cyc, stl, urn, t0, nb;
    logic [31:0] pd;
    logic pl;
    bit hold;
    acc = 0; outn = 0; cyc = 0; stl = 0; urn = 0; t0 = -1; hold = 0;
    pd = '0; pl = 1'b0;
    pe = 1'b0;
    while (outn < 16 && cyc < 4000) begin
      @(negedge clk);
      m_tready = ((cyc % period) == 0);
      s_tvalid = (acc < 16) && !(acc == stall_at && stl < stall_len);
      if (acc == stall_at && stl < stall_len) stl++;
      s_tdata = base + 32'(acc);
      count = 32'(16 - acc);
      #1;
      if (hold)
        check("hold", {31'd0, m_tvalid, m_tlast, m_tdata},
              {31'd0, 1'b1, pl, pd});
      if (m_tvalid && !m_tready)
        check("full_rdy", {63'd0, s_tready}, 64'd0);
      if (und) urn++;
      if (m_tvalid && m_tready) begin
        check("data", {32'd0, m_tdata}, {32'd0, base + 32'(outn)});
        check("tlast", {63'd0, m_tlast}, {63'd0, outn == 15});
        if (period == 1 && stall_len == 0)
          check("timing", 64'(cyc), 64'(t0 + 1 + outn));
        outn++;
      end
      hold = m_tvalid && !m_tready;
      pd = m_tdata;
      pl = m_tlast;
      if (s_tvalid && s_tready) begin
        if (t0 < 0) t0 = cyc;
        acc++;
      end
      cyc++;
      if (abort_at > 0 && acc == abort_at) return;
    end
    check("beats", 64'(outn), 64'd16);
    check("underruns", 64'(urn), 64'(stall_len));
    s_tvalid = 1'b0;
    count = '0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (!busy) break;
      nb++;
    end
    check("gap_busy", 64'(nb), 64'(exp_gap));
  endtask

  initial begin
    int n, k, idle, cyc;
    bit seen;
`ifdef AXIS_BURST_DRAIN_STATS_EN
    logic [15:0] uc_before;
`endif
    resetn = 1'b0; count = '0; pe = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b0;
    count0 = '0; s_tdata0 = '0; s_tvalid0 = 1'b0;
    repeat (2) @(negedge clk);

    //            rn cnt pe sv sd     mr  busy str mv md    ml und cd
    vecs[0]  = '{0, 0,  0, 0, 0,     0,  0,   0,  0, 0,    0, 0,  1};
    vecs[1]  = '{1, 15, 0, 0, 0,     0,  0,   0,  0, 0,    0, 0,  1};
    vecs[2]  = '{1, 16, 1, 0, 0,     0,  0,   0,  0, 0,    0, 0,  1};
    vecs[3]  = '{1, 16, 0, 0, 0,     1,  0,   0,  0, 0,    0, 0,  1};
    vecs[4]  = '{1, 16, 0, 0, 0,     1,  1,   1,  0, 0,    0, 1,  1};
    vecs[5]  = '{1, 16, 0, 1, 'hA0,  1,  1,   1,  0, 0,    0, 0,  1};
    vecs[6]  = '{1, 15, 0, 1, 'hA1,  0,  1,   0,  1, 'hA0, 0, 0,  1};
    vecs[7]  = '{1, 15, 0, 1, 'hA1,  0,  1,   0,  1, 'hA0, 0, 0,  1};
    vecs[8]  = '{1, 15, 0, 1, 'hA1,  1,  1,   1,  1, 'hA0, 0, 0,  1};
    vecs[9]  = '{1, 14, 1, 0, 0,     1,  1,   1,  1, 'hA1, 0, 1,  1};
    vecs[10] = '{1, 14, 0, 0, 0,     0,  1,   1,  0, 0,    0, 1,  0};
    vecs[11] = '{0, 14, 0, 1, 'hA2,  1,  0,   0,  0, 0,    0, 0,  0};
    vecs[12] = '{1, 0,  0, 0, 0,     0,  0,   0,  0, 0,    0, 0,  1};

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      resetn = vecs[i].rn; count = vecs[i].cnt; pe = vecs[i].pe;
      s_tvalid = vecs[i].sv; s_tdata = vecs[i].sd;
      m_tready = vecs[i].mr;
      #1;
      check($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].busy});
      check($sformatf("v%0d_srdy", i), {63'd0, s_tready}, {63'd0, vecs[i].str});
      check($sformatf("v%0d_mvld", i), {63'd0, m_tvalid}, {63'd0, vecs[i].mv});
      check($sformatf("v%0d_mlast", i), {63'd0, m_tlast}, {63'd0, vecs[i].ml});
      check($sformatf("v%0d_und", i), {63'd0, und}, {63'd0, vecs[i].und});
      if (vecs[i].cd)
        check($sformatf("v%0d_mdata", i), {32'd0, m_tdata}, {32'd0, vecs[i].md});
    end

    // Count one short of a burst must never start one.
    s_tvalid = 1'b0; m_tready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      count = 32'd15; pe = 1'b0;
      #1;
      check("below_busy", {63'd0, busy}, 64'd0);
      check("below_rdy", {63'd0, s_tready}, 64'd0);
    end
    @(negedge clk);
    count = 32'd16;
    #1;
    check("start_idle", {63'd0, busy}, 64'd0);
    @(negedge clk);
    #1;
    check("start_busy", {63'd0, busy}, 64'd1);
    check("start_und", {63'd0, und}, 64'd1);
    run_burst(32'd0, 1, -1, 0, 0, 4);

    run_burst(32'h100, 101, -1, 0, 0, 4);

`ifdef AXIS_BURST_DRAIN_STATS_EN
    uc_before = uc;
`endif
    run_burst(32'h200, 1, 6, 3, 0, 4);
`ifdef AXIS_BURST_DRAIN_STATS_EN
    check("underrun_count", {48'd0, uc}, {48'd0, uc_before + 16'd3});
`endif

    run_burst(32'h300, 1, -1, 0, 9, 4);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_beat", {31'd0, m_tvalid, m_tdata}, {31'd0, 1'b1, 32'h308});
    check("abort_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    resetn = 1'b1; count = '0; s_tvalid = 1'b0;
    #1;
    check("rst_mvld", {63'd0, m_tvalid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_tlast", {63'd0, m_tlast}, 64'd0);
    run_burst(32'h400, 1, -1, 0, 0, 4);

    // Zero-gap instance: four back-to-back bursts.
    count0 = 32'd64; s_tvalid0 = 1'b1;
    n = 0; k = 0; idle = 0; cyc = 0; seen = 0;
    while (n < 64 && cyc < 1000) begin
      @(negedge clk);
      s_tdata0 = 32'(k);
      #1;
      if (m_tvalid0) begin
        check("b2b_data", {32'd0, m_tdata0}, 64'(n));
        check("b2b_tlast", {63'd0, m_tlast0}, {63'd0, (n % 16) == 15});
        n++;
        seen = 1;
      end
      if (seen && !busy0) idle++;
      if (s_tready0) k++;
      cyc++;
    end
    check("b2b_beats", 64'(n), 64'd64);
    check("b2b_idle", 64'(idle), 64'd3);
`ifdef AXIS_BURST_DRAIN_STATS_EN
    @(negedge clk);
    #1;
    check("burst_count", {32'd0, bc0}, 64'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_burst_drain.md
Name: axis_burst_drain

Overview:
- Consumer at the read end of the transmit-path dual FIFO.
- Watches the FIFO fill level (axis_rd_data_count, prog_empty).
- Once a full burst is buffered, drains exactly BURST_LEN beats from the FIFO's AXI4-Stream master port.
- Re-emits them on a registered AXI4-Stream master with tlast on the final beat, then enforces an inter-burst gap.

Parameters:
- DATA_W, 32, tdata width of both stream ports.
- BURST_LEN, 16, beats per burst/packet; legal range 2..65535.
- CNT_W, 32, width of the FIFO read data count input.
- GAP_CYCLES, 4, idle cycles inserted after each burst completes; 0 allowed.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  reset, synchronous, active-low.
- axis_rd_data_count  in  CNT_W  FIFO read-side occupancy in beats.
- prog_empty  in  1  FIFO programmable-empty flag.
- s_axis_tdata  in  DATA_W  data from the FIFO.
- s_axis_tvalid  in  1  FIFO data valid.
- s_axis_tready  out  1  drain accepts a beat.
- m_axis_tdata  out  DATA_W  registered output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on beat BURST_LEN-1 of each burst.
- busy  out  1  high in any state other than IDLE.
- underrun  out  1  one-cycle pulse when a beat is starved mid-burst.

Behaviour:
- Reset (resetn low at a clk edge): state=IDLE; beat_cnt=0; gap_cnt=0.
  - Outputs during reset: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, s_axis_tready=0, busy=0, underrun=0.
  - Reset mid-burst aborts immediately: the held output beat is dropped and no tlast is produced. Beats already taken from the FIFO are lost.
- FSM states: IDLE, BURST, FLUSH, GAP.
- IDLE -> BURST when axis_rd_data_count >= BURST_LEN and prog_empty=0, sampled at a clk edge; beat_cnt cleared.
- BURST:
  - s_axis_tready = (!m_axis_tvalid || m_axis_tready). s_axis_tready is 0 in every other state.
  - Accept = s_axis_tvalid && s_axis_tready. On accept: the output register loads s_axis_tdata, m_axis_tvalid=1 next cycle, and beat_cnt increments.
  - m_axis_tlast = 1 with the beat whose pre-increment beat_cnt == BURST_LEN-1.
  - On that final accept, go to FLUSH.
- Latency: 1 cycle from s-side accept to m_axis_tvalid. Throughput is one beat per cycle while m_axis_tready=1.
- Output register hold:
  - m_axis_tvalid=1 with m_axis_tready=0 holds tdata, tvalid and tlast stable.
  - A simultaneous output handshake and new accept reloads the register in the same edge, with no bubble.
- underrun: pulses when in BURST, s_axis_tready=1 and s_axis_tvalid=0. The FSM stays in BURST and waits; there is no timeout.
- FLUSH -> GAP (or IDLE if GAP_CYCLES=0) on the cycle the tlast beat handshakes (m_axis_tvalid && m_axis_tready && m_axis_tlast). m_axis_tvalid=0 the following cycle unless a new beat is loaded, which cannot happen in FLUSH.
- GAP: gap_cnt counts 0..GAP_CYCLES-1, then -> IDLE. The IDLE check for the next burst happens on the following edge.
- axis_rd_data_count is compared in full CNT_W width, unsigned. A BURST_LEN exceeding the count range never triggers.
- prog_empty=1 blocks starting a burst only; it is ignored once in BURST.

Optional Feature:
- Macro: AXIS_BURST_DRAIN_STATS_EN.
- Defined:
  - Adds output burst_count (32 bits): increments on each FLUSH exit, wraps at 2^32.
  - Adds output underrun_count (16 bits): increments on each underrun pulse, saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: both ports and counters are absent; all other behaviour is identical.

Test Plan:
- Count=15, prog_empty=0 for 50 cycles -> busy=0, s_axis_tready=0 throughout; count then set to 16 -> busy=1 the next cycle.
- BURST_LEN=16, FIFO streaming 0..15, m_axis_tready=1 -> 16 output beats 0..15 on consecutive cycles, first beat 1 cycle after the first accept, tlast only on 15; after the tlast handshake, busy stays high 4 cycles then drops.
- Downstream ready 1-in-101 (high 1, low 100) -> each beat held stable until its handshake, s_axis_tready low while the register is full, no data loss, 16 beats in order.
- FIFO tvalid dropped for 3 cycles after beat 5 -> exactly 3 underrun pulses, beats 6..15 follow in order, tlast still on beat 15 (with the macro defined: underrun_count=3).
- Reset asserted at beat 8 of a burst -> next edge m_axis_tvalid=0, busy=0, tlast never seen; after release with count>=16 a fresh burst starts with beat_cnt=0.
- GAP_CYCLES=0, count held at 64 -> four back-to-back bursts of 16, tlast on every 16th beat, 1-cycle IDLE between bursts (with the macro defined: burst_count=4).
